// File: rtl/roi_scan_pkg.sv
// Shared state encoding and elaboration helpers for the ROI scan controller.
package roi_scan_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    LOAD      = 3'd2,
    SETTLE    = 3'd3,
    CAPTURE   = 3'd4,
    SHIFT_OUT = 3'd5,
    DONE      = 3'd6
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/roi_scan_shreg.sv
// Parallel-load, MSB-first shift register; o_next is the value one shift would produce.
module roi_scan_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_load_val,
  input  logic         i_shift_in,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_next
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_next;

  assign w_next[0] = i_shift_in;
  for (genvar gi = 1; gi < W; gi++) begin : g_shift
    assign w_next[gi] = r_q[gi-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= w_next;
    end
  end

  assign o_q    = r_q;
  assign o_next = w_next;

endmodule

// File: rtl/roi_scan_ctrl.sv
// Scan controller: shifts a word into the ROI harness, strobes load/capture,
// then shifts the captured result back out, MSB first.
module roi_scan_ctrl
  import roi_scan_pkg::*;
#(
  parameter int DIN_N      = 8,
  parameter int DOUT_N     = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [((DIN_N > 0) ? DIN_N : 1)-1:0] din_word,
  output logic                                 busy,
  output logic                                 done,
  output logic [DOUT_N-1:0]                    dout_word,
  output logic                                 di,
  output logic                                 stb,
  input  logic                                 do_i
);

  localparam int DIN_W = (DIN_N > 0) ? DIN_N : 1;
  localparam int CNT_W = $clog2(max3(DIN_N, DOUT_N, SETTLE_CYC) + 1);

  localparam logic [CNT_W-1:0] LAST_IN     = CNT_W'((DIN_N > 0) ? DIN_N - 1 : 0);
  localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_OUT    = CNT_W'(DOUT_N - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_stb;
  logic [DOUT_N-1:0]  r_dout;

  logic               w_accept;
  logic               w_in_load;
  logic [DIN_W-1:0]   w_in_q;
  logic [DIN_W-1:0]   w_in_next;
  logic [DOUT_N-1:0]  w_out_q;
  logic [DOUT_N-1:0]  w_out_next;
  logic               w_unused;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_in_load = w_accept && (DIN_N > 0);

  // Scan-in register shifts zeros in behind the data, so its MSB is di and
  // naturally returns to 0 once the last bit has gone out.
  roi_scan_shreg #(.W(DIN_W)) u_scan_in (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_in_load),
    .i_shift    (r_state == SHIFT_IN),
    .i_load_val (din_word),
    .i_shift_in (1'b0),
    .o_q        (w_in_q),
    .o_next     (w_in_next)
  );

  roi_scan_shreg #(.W(DOUT_N)) u_scan_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_shift    (r_state == SHIFT_OUT),
    .i_load_val ('0),
    .i_shift_in (do_i),
    .o_q        (w_out_q),
    .o_next     (w_out_next)
  );

  assign w_unused = &{1'b0, w_in_q, w_in_next, w_out_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_stb   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (DIN_N > 0) begin
              r_state <= SHIFT_IN;
            end else begin
              r_state <= LOAD;
              r_stb   <= 1'b1;
            end
          end
        end
        SHIFT_IN: begin
          if (r_cnt == LAST_IN) begin
            r_cnt   <= '0;
            r_state <= LOAD;
            r_stb   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        LOAD: begin
          r_stb   <= 1'b0;
          r_cnt   <= '0;
          r_state <= SETTLE;
        end
        SETTLE: begin
          if (r_cnt == LAST_SETTLE) begin
            r_cnt   <= '0;
            r_state <= CAPTURE;
            r_stb   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          r_stb   <= 1'b0;
          r_cnt   <= '0;
          r_state <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          // The final do_i sample is folded straight into the result here.
          if (r_cnt == LAST_OUT) begin
            r_cnt   <= '0;
            r_state <= DONE;
            r_done  <= 1'b1;
            r_dout  <= w_out_next;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_stb   <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign stb       = r_stb;
  assign dout_word = r_dout;
  assign di        = w_in_q[DIN_W-1];

endmodule

// File: tb/tb_roi_scan_ctrl.sv
// Self-checking bench: harness model with bit-reversing ROI around an 8/8/4
// controller, plus a 0/1/1 instance for the empty scan-in corner.
module tb_roi_scan_ctrl;

  localparam int N  = 8;
  localparam int M  = 8;
  localparam int S  = 4;
  localparam int EXP_LAT  = N + S + M + 3;
  localparam int EXP_STB1 = N + 1;
  localparam int EXP_STB2 = N + S + 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] din_word;
  logic       busy, done, di, stb, do_i;
  logic [7:0] dout_word;

  logic       start2;
  logic [0:0] din2;
  logic       busy2, done2, di2, stb2, do_i2;
  logic [0:0] dout2;

  int n_tests = 0;
  int n_fail  = 0;
  int done_total = 0;

  roi_scan_ctrl #(.DIN_N(N), .DOUT_N(M), .SETTLE_CYC(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din_word(din_word),
    .busy(busy), .done(done), .dout_word(dout_word),
    .di(di), .stb(stb), .do_i(do_i)
  );

  roi_scan_ctrl #(.DIN_N(0), .DOUT_N(1), .SETTLE_CYC(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start2), .din_word(din2),
    .busy(busy2), .done(done2), .dout_word(dout2),
    .di(di2), .stb(stb2), .do_i(do_i2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Harness: serial-in register feeds the ROI on stb; ROI output (bit-reversed
  // input) is loaded into the serial-out register on stb.
  logic [7:0] h_sin  = '0;
  logic [7:0] h_roi  = '0;
  logic [7:0] h_sout = '0;
  always @(posedge clk) begin
    if (stb) begin
      h_roi  <= h_sin;
      h_sout <= {<<{h_roi}};
    end else begin
      h_sin  <= {h_sin[6:0], di};
      h_sout <= {h_sout[6:0], 1'b0};
    end
  end
  assign do_i = h_sout[7];

  logic h2_val  = 1'b0;
  logic h2_sout = 1'b0;
  always @(posedge clk) if (stb2) h2_sout <= h2_val;
  assign do_i2 = h2_sout;

  always @(negedge clk) if (done === 1'b1) done_total++;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_dout;
  } vec_t;
  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  // noise: 0 = start held low while busy, 1 = random start while busy,
  // 2 = start pulsed in cycle 5 and on the done cycle.
  task automatic run_main(input logic [7:0] din, input int noise, input logic [7:0] exp_dout);
    logic [7:0] di_seen, dout_at_done;
    int lat, stb_n, stb_first, stb_second, di_bad, busy_bad, dones, stb_pair;
    logic prev_stb;
    di_seen = '0; dout_at_done = '0; lat = 0; stb_n = 0; stb_first = 0; stb_second = 0;
    di_bad = 0; busy_bad = 0; dones = 0; stb_pair = 0; prev_stb = 1'b0;
    start = 1'b1;
    din_word = din;
    tick();
    din_word = 8'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc <= N) di_seen[N-cyc] = di;
      else if (di !== 1'b0) di_bad++;
      if (stb === 1'b1) begin
        stb_n++;
        if (prev_stb) stb_pair++;
        if (stb_n == 1) stb_first = cyc;
        else if (stb_n == 2) stb_second = cyc;
      end
      prev_stb = stb;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        lat = cyc;
        dones++;
        dout_at_done = dout_word;
      end
      case (noise)
        1: start = 1'($urandom_range(0, 1));
        2: start = (cyc == 5) || (done === 1'b1);
        default: start = 1'b0;
      endcase
      tick();
      if (lat != 0) break;
    end
    start = 1'b0;
    chk("latency", lat, EXP_LAT);
    chk("dout_at_done", dout_at_done, exp_dout);
    chk("di_sequence", di_seen, din);
    chk("di_zero_outside_shift", di_bad, 0);
    chk("stb_count", stb_n, 2);
    chk("stb_load_cycle", stb_first, EXP_STB1);
    chk("stb_capture_cycle", stb_second, EXP_STB2);
    chk("stb_consecutive", stb_pair, 0);
    chk("busy_during", busy_bad, 0);
    chk("done_count", dones, 1);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("dout_held", dout_word, exp_dout);
    $display("[TB] txn din=%02h dout=%02h exp=%02h lat=%0d noise=%0d", din, dout_at_done, exp_dout, lat, noise);
  endtask

  task automatic run_small(input logic val);
    int lat, stb_n, stb_first, stb_second, di_bad;
    logic dout_at_done;
    lat = 0; stb_n = 0; stb_first = 0; stb_second = 0; di_bad = 0; dout_at_done = 1'bx;
    h2_val = val;
    din2 = 1'b1;
    start2 = 1'b1;
    if (di2 !== 1'b0) di_bad++;
    tick();
    start2 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (di2 !== 1'b0) di_bad++;
      if (stb2 === 1'b1) begin
        stb_n++;
        if (stb_n == 1) stb_first = cyc;
        else if (stb_n == 2) stb_second = cyc;
      end
      if (done2 === 1'b1) begin
        lat = cyc;
        dout_at_done = dout2[0];
      end
      tick();
      if (lat != 0) break;
    end
    chk("small_latency", lat, 5);
    chk("small_stb_load", stb_first, 1);
    chk("small_stb_capture", stb_second, 3);
    chk("small_stb_count", stb_n, 2);
    chk("small_dout", dout_at_done, val);
    chk("small_di_zero", di_bad, 0);
    chk("small_busy_after", busy2, 0);
    $display("[TB] txn small val=%0d dout=%0d lat=%0d", val, dout_at_done, lat);
  endtask

  initial begin
    logic [7:0] d;
    int gap, d0;

    vecs[0] = '{8'hA5, 8'hA5};
    vecs[1] = '{8'h01, 8'h80};
    vecs[2] = '{8'h80, 8'h01};
    vecs[3] = '{8'hF0, 8'h0F};
    vecs[4] = '{8'h00, 8'h00};
    vecs[5] = '{8'hFF, 8'hFF};
    vecs[6] = '{8'h12, 8'h48};
    vecs[7] = '{8'h6C, 8'h36};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; din_word = '0; din2 = '0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stb", stb, 0);
    chk("rst_di", di, 0);
    chk("rst_dout", dout_word, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_stb2", stb2, 0);
    chk("rst_dout2", dout2, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_main(vecs[i].din, 0, vecs[i].exp_dout);
      tick();
    end

    // Start while busy and on the done cycle ignored; start in the next idle cycle accepted.
    run_main(8'h3C, 2, 8'h3C);
    run_main(8'hC5, 0, 8'hA3);
    tick();

    for (int t = 0; t < 16; t++) begin
      d = 8'($urandom);
      run_main(d, 1, rev8(d));
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
    end

    // Reset during SETTLE aborts without a done pulse.
    run_main(8'hC3, 0, 8'hC3);
    tick();
    start = 1'b1;
    din_word = 8'h5A;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pre_reset_busy", busy, 1);
    d0 = done_total;
    rst_n = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dout", dout_word, 0);
    chk("abort_stb", stb, 0);
    chk("abort_di", di, 0);
    rst_n = 1'b1;
    repeat (30) tick();
    chk("abort_no_done", done_total - d0, 0);
    chk("abort_idle", busy, 0);
    run_main(8'h5A, 0, 8'h5A);

    run_small(1'b1);
    tick();
    run_small(1'b0);
    run_small(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
